// File: rtl/byte_serial_adder_ctrl.sv
// Byte-serial WIDTH-bit adder: a single 8-bit ripple adder (cra8) is reused once per byte, LSB first.
// Optional subtract path is compiled in with `define SERIAL_SUB_EN.

module cra8 (
    input  logic [7:0] x_i,
    input  logic [7:0] y_i,
    input  logic       c_i,
    output logic [7:0] f_o,
    output logic       c_o
);
    logic [8:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign f_o[i]   = x_i[i] ^ y_i[i] ^ c[i];
        assign c[i + 1] = (x_i[i] & y_i[i]) | (x_i[i] & c[i]) | (y_i[i] & c[i]);
    end

    assign c_o = c[8];
endmodule

module byte_serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic [1:0]       state_o
);
    // WIDTH must be a multiple of 8 and at least 8.
    localparam int NBYTES = WIDTH / 8;
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDXW-1:0]  idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             busy_q;

    logic [WIDTH-1:0] b_eff_d;
    logic             carry_init_d;
    logic [7:0]       x_byte;
    logic [7:0]       y_byte;
    logic [7:0]       f_byte;
    logic             c_byte;
    logic [WIDTH-1:0] sum_d;
    logic             last_byte;
    logic             ovf_d;
    logic             zero_d;

`ifdef SERIAL_SUB_EN
    // Two's-complement subtract: invert b and force the initial carry to 1.
    assign b_eff_d      = sub_i ? ~b_i : b_i;
    assign carry_init_d = sub_i ? 1'b1 : cin_i;
`else
    logic unused_sub;
    assign unused_sub   = sub_i;
    assign b_eff_d      = b_i;
    assign carry_init_d = cin_i;
`endif

    always_comb begin
        x_byte = '0;
        y_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IDXW'(i)) begin
                x_byte = a_q[8*i +: 8];
                y_byte = b_q[8*i +: 8];
            end
        end
    end

    cra8 u_cra8 (
        .x_i (x_byte),
        .y_i (y_byte),
        .c_i (carry_q),
        .f_o (f_byte),
        .c_o (c_byte)
    );

    always_comb begin
        sum_d = sum_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IDXW'(i)) begin
                sum_d[8*i +: 8] = f_byte;
            end
        end
    end

    // Flags are taken from the fully assembled sum on the final RUN cycle.
    assign last_byte = (idx_q == IDXW'(NBYTES - 1));
    assign ovf_d     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
    assign zero_d    = ~|sum_d;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    // in_ready is 1 only in IDLE; out_valid stays high, outputs frozen, until out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        a_q        <= a_i;
                        b_q        <= b_eff_d;
                        carry_q    <= carry_init_d;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= c_byte;
                    if (last_byte) begin
                        idx_q       <= '0;
                        cout_q      <= c_byte;
                        ovf_q       <= ovf_d;
                        zero_q      <= zero_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;
    assign zero_o      = zero_q;
    assign busy_o      = busy_q;
    assign state_o     = state_q;
endmodule
